// File: rtl/irq_timer_port.sv
// Memory-mapped interrupt source for the cpu4510 bus: 16-bit down-counter,
// software force bits, level irq and nmi outputs, and registered read data.
module irq_timer_port #(
  parameter logic [19:0] BASE      = 20'h0BFF0,
  parameter logic [15:0] RESET_CNT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_i,
  input  logic        ready,
  output logic        sel,
  output logic [7:0]  data_o,
  output logic        irq,
  output logic        nmi
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CNT_LO = 3'd2;
  localparam logic [2:0] OFF_CNT_HI = 3'd3;
  localparam logic [2:0] OFF_FORCE  = 3'd4;

  // Bus handshake: an access completes on the rising edge where sel and ready
  // are both 1; write_next picks direction. ready=0 stalls accesses and ticks.
  logic [3:0]  ctrl_q, ctrl_d;
  logic        irq_pend_q, irq_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lo_latch_q, lo_latch_d;
  logic [7:0]  data_o_q, data_o_d;
  logic        irq_q, irq_d;
  logic        nmi_q, nmi_d;

  logic [2:0]  off;
  logic        wr;
  logic        rd;
  logic        tick;
  logic        hi_wr;
  logic        expire;
  logic        irq_en;
  logic        nmi_en;
  logic        auto_reload;
  logic        run;
  logic        set_irq;
  logic        set_nmi;
  logic        clr_irq;
  logic        clr_nmi;
  logic [7:0]  rdata;

  assign sel         = (address_next[19:3] == BASE[19:3]);
  assign off         = address_next[2:0];
  assign wr          = sel & ready & write_next;
  assign rd          = sel & ready & ~write_next;
  assign irq_en      = ctrl_q[0];
  assign nmi_en      = ctrl_q[1];
  assign auto_reload = ctrl_q[2];
  assign run         = ctrl_q[3];

  assign tick   = ready & run;
  assign hi_wr  = wr & (off == OFF_CNT_HI);
  // A CNT_HI write landing on the zero tick replaces the count, so no expiry.
  assign expire = tick & (cnt_q == 16'd0) & ~hi_wr;

  assign set_irq = (expire & irq_en) | (wr & (off == OFF_FORCE) & data_i[0]);
  assign set_nmi = (expire & nmi_en) | (wr & (off == OFF_FORCE) & data_i[1]);
  assign clr_irq = wr & (off == OFF_STATUS) & data_i[0];
  assign clr_nmi = wr & (off == OFF_STATUS) & data_i[1];

  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_CTRL:   rdata = {4'h0, ctrl_q};
      OFF_STATUS: rdata = {6'h00, nmi_pend_q, irq_pend_q};
      OFF_CNT_LO: rdata = cnt_q[7:0];
      OFF_CNT_HI: rdata = cnt_q[15:8];
      default:    rdata = 8'h00;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    reload_d   = reload_q;
    cnt_d      = cnt_q;
    lo_latch_d = lo_latch_q;
    data_o_d   = data_o_q;

    if (expire && !auto_reload) begin
      ctrl_d[3] = 1'b0;
    end
    // A CTRL write takes priority over the expiry clearing run.
    if (wr && (off == OFF_CTRL)) begin
      ctrl_d = data_i[3:0];
    end

    if (wr && (off == OFF_CNT_LO)) begin
      lo_latch_d = data_i;
    end

    if (hi_wr) begin
      reload_d = {data_i, lo_latch_q};
      cnt_d    = {data_i, lo_latch_q};
    end else if (expire) begin
      cnt_d = auto_reload ? reload_q : 16'd0;
    end else if (tick) begin
      cnt_d = cnt_q - 16'd1;
    end

    if (rd) begin
      data_o_d = rdata;
    end

    // Set beats a same-cycle w1c clear.
    irq_pend_d = set_irq | (irq_pend_q & ~clr_irq);
    nmi_pend_d = set_nmi | (nmi_pend_q & ~clr_nmi);

    irq_d = irq_pend_q & irq_en;
    nmi_d = nmi_pend_q & nmi_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= 4'h0;
      irq_pend_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      reload_q   <= RESET_CNT;
      cnt_q      <= RESET_CNT;
      lo_latch_q <= 8'h00;
      data_o_q   <= 8'h00;
      irq_q      <= 1'b0;
      nmi_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      irq_pend_q <= irq_pend_d;
      nmi_pend_q <= nmi_pend_d;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      lo_latch_q <= lo_latch_d;
      data_o_q   <= data_o_d;
      irq_q      <= irq_d;
      nmi_q      <= nmi_d;
    end
  end

  assign data_o = data_o_q;
  assign irq    = irq_q;
  assign nmi    = nmi_q;

endmodule

// File: tb/tb_irq_timer_port.sv
// Directed self-checking bench for irq_timer_port: reset, one-shot, auto-reload,
// nmi force/clear race, enables, decode, CNT_HI-on-expiry and mid-run reset.
module tb_irq_timer_port;

  localparam logic [19:0] BASE = 20'h0BFF0;
  localparam logic [19:0] IDLE = 20'h00000;

  logic        clk;
  logic        reset_n;
  logic [19:0] address_next;
  logic        write_next;
  logic [7:0]  data_i;
  logic        ready;
  logic        sel;
  logic [7:0]  data_o;
  logic        irq;
  logic        nmi;

  int checks;
  int errors;

  irq_timer_port #(.BASE(BASE), .RESET_CNT(16'hFFFF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address_next(address_next),
    .write_next(write_next),
    .data_i(data_i),
    .ready(ready),
    .sel(sel),
    .data_o(data_o),
    .irq(irq),
    .nmi(nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go_idle();
    address_next = IDLE;
    write_next   = 1'b0;
    data_i       = 8'h00;
    ready        = 1'b1;
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [7:0] d);
    @(negedge clk);
    address_next = addr;
    write_next   = 1'b1;
    data_i       = d;
    ready        = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
  endtask

  task automatic do_read(input logic [19:0] addr, output logic [7:0] d);
    @(negedge clk);
    address_next = addr;
    write_next   = 1'b0;
    ready        = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
    d = data_o;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    reset_n = 1'b1;
    go_idle();
    #($urandom_range(3, 17));
    reset_n = 1'b0;
    #2;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0h want 0", irq); end
    checks++;
    if (nmi !== 1'b0) begin errors++; $display("FAIL reset_nmi got %0h want 0", nmi); end
    checks++;
    if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data_o got %02h want 00", data_o); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_read(BASE + 20'd2, rd);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("FAIL reset_cnt_lo got %02h want FF", rd); end
    do_read(BASE + 20'd3, rd);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("FAIL reset_cnt_hi got %02h want FF", rd); end
  endtask

  task automatic test_one_shot();
    logic [7:0] rd;
    logic       exp;
    do_write(BASE + 20'd2, 8'h03);
    do_write(BASE + 20'd3, 8'h00);
    do_write(BASE + 20'd0, 8'h09);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      exp = (k >= 5);
      checks++;
      if (irq !== exp) begin errors++; $display("FAIL one_shot_irq clk %0d got %0h want %0h", k, irq, exp); end
    end
    do_read(BASE + 20'd0, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL one_shot_ctrl got %02h want 01", rd); end
    do_read(BASE + 20'd1, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL one_shot_status got %02h want 01", rd); end
    do_read(BASE + 20'd2, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL one_shot_cnt_lo got %02h want 00", rd); end
    do_write(BASE + 20'd1, 8'h03);
    do_write(BASE + 20'd0, 8'h00);
  endtask

  task automatic test_auto_reload();
    logic exp;
    do_write(BASE + 20'd2, 8'h02);
    do_write(BASE + 20'd3, 8'h00);
    do_write(BASE + 20'd0, 8'h0D);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 8) begin
        address_next = BASE + 20'd1;
        write_next   = 1'b1;
        data_i       = 8'h01;
        ready        = 1'b1;
      end else begin
        address_next = IDLE;
        write_next   = 1'b0;
        ready        = ((k % 2) == 0);
      end
      @(posedge clk);
      #1;
      exp = (k == 7) || (k == 8) || (k == 13);
      checks++;
      if (irq !== exp) begin errors++; $display("FAIL auto_irq clk %0d got %0h want %0h", k, irq, exp); end
    end
    go_idle();
    do_write(BASE + 20'd0, 8'h00);
    do_write(BASE + 20'd1, 8'h03);
  endtask

  task automatic test_nmi_force();
    logic [7:0] rd;
    do_write(BASE + 20'd0, 8'h02);
    do_write(BASE + 20'd4, 8'h02);
    checks++;
    if (nmi !== 1'b0) begin errors++; $display("FAIL force_nmi_early got %0h want 0", nmi); end
    @(posedge clk);
    #1;
    checks++;
    if (nmi !== 1'b1) begin errors++; $display("FAIL force_nmi got %0h want 1", nmi); end
    do_write(BASE + 20'd2, 8'h00);
    do_write(BASE + 20'd3, 8'h00);
    do_write(BASE + 20'd0, 8'h0E);
    do_write(BASE + 20'd1, 8'h02);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (nmi !== 1'b1) begin errors++; $display("FAIL race_nmi clk %0d got %0h want 1", k, nmi); end
    end
    do_read(BASE + 20'd1, rd);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL race_status got %02h want 02", rd); end
    do_write(BASE + 20'd0, 8'h02);
    do_write(BASE + 20'd1, 8'h02);
    @(posedge clk);
    #1;
    checks++;
    if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_clear got %0h want 0", nmi); end
    do_write(BASE + 20'd0, 8'h00);
  endtask

  task automatic test_enable_and_reset();
    logic [7:0] rd;
    do_write(BASE + 20'd0, 8'h01);
    do_write(BASE + 20'd4, 8'h01);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL force_irq got %0h want 1", irq); end
    do_write(BASE + 20'd0, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got %0h want 0", irq); end
    do_read(BASE + 20'd1, rd);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL pend_kept got %02h want 01", rd); end
    do_write(BASE + 20'd0, 8'h01);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_reenabled got %0h want 1", irq); end
    #($urandom_range(1, 8));
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %0h want 0", irq); end
    @(negedge clk);
    reset_n = 1'b1;
    do_read(BASE + 20'd1, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL midreset_status got %02h want 00", rd); end
    do_read(BASE + 20'd0, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL midreset_ctrl got %02h want 00", rd); end
    do_read(BASE + 20'd3, rd);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("FAIL midreset_cnt_hi got %02h want FF", rd); end
  endtask

  task automatic test_decode();
    logic [7:0] rd;
    @(negedge clk);
    address_next = BASE + 20'd8;
    #1;
    checks++;
    if (sel !== 1'b0) begin errors++; $display("FAIL sel_above got %0h want 0", sel); end
    address_next = BASE - 20'd1;
    #1;
    checks++;
    if (sel !== 1'b0) begin errors++; $display("FAIL sel_below got %0h want 0", sel); end
    address_next = BASE + 20'd7;
    #1;
    checks++;
    if (sel !== 1'b1) begin errors++; $display("FAIL sel_inside got %0h want 1", sel); end
    go_idle();
    do_write(BASE + 20'd8, 8'h0F);
    do_write(BASE + 20'd10, 8'h77);
    do_write(BASE - 20'd1, 8'hFF);
    do_read(BASE + 20'd0, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL decode_ctrl got %02h want 00", rd); end
    do_write(BASE + 20'd2, 8'h5A);
    do_write(BASE + 20'd3, 8'hA5);
    do_read(BASE + 20'd3, rd);
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL decode_cnt_hi got %02h want A5", rd); end
    do_read(BASE + 20'd11, rd);
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL unselected_hold got %02h want A5", rd); end
    do_read(BASE + 20'd5, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL read_off5 got %02h want 00", rd); end
    do_read(BASE + 20'd2, rd);
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL decode_cnt_lo got %02h want 5A", rd); end
    @(negedge clk);
    address_next = BASE + 20'd3;
    ready        = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_o !== 8'h5A) begin errors++; $display("FAIL stall_hold got %02h want 5A", data_o); end
    go_idle();
  endtask

  task automatic test_hi_on_expiry();
    logic [7:0] rd;
    do_write(BASE + 20'd2, 8'h01);
    do_write(BASE + 20'd3, 8'h00);
    do_write(BASE + 20'd2, 8'h34);
    do_write(BASE + 20'd0, 8'h09);
    @(posedge clk);
    do_write(BASE + 20'd3, 8'h12);
    do_write(BASE + 20'd0, 8'h00);
    do_read(BASE + 20'd1, rd);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL hi_exp_status got %02h want 00", rd); end
    do_read(BASE + 20'd3, rd);
    checks++;
    if (rd !== 8'h12) begin errors++; $display("FAIL hi_exp_cnt_hi got %02h want 12", rd); end
    do_read(BASE + 20'd2, rd);
    checks++;
    if (rd !== 8'h33) begin errors++; $display("FAIL hi_exp_cnt_lo got %02h want 33", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL hi_exp_irq got %0h want 0", irq); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_nmi_force();
    test_enable_and_reset();
    test_decode();
    test_hi_on_expiry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
